// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss BCD timer core with button sync/debounce,
// selectable count direction, exact tick prescaler and a DONE flash output.

// Button conditioner: two-flop synchroniser, stability debounce, and a
// one-cycle press pulse on the accepted released->pressed (1->0) edge.
module bcd_timer_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic CLOCK_50,
  input  logic reset_btn,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw pin and accept a new level only after it is stable long enough.
  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      level_r   <= 1'b1;
      level_d_r <= 1'b1;
      cnt_r     <= {CW{1'b0}};
    end else begin
      sync1_r   <= btn_raw;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign press = level_d_r & ~level_r;
endmodule

module bcd_countdown_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int FLASH_HZ     = 2,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset_btn,
  input  logic        set_btn,
  input  logic        run_btn,
  input  logic        count_up,
  input  logic [7:0]  sw,
  output logic [15:0] digits,
  output logic [2:0]  state,
  output logic        done,
  output logic [9:0]  led_flash
);
  localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int FLASH_DIV = CLK_HZ / (2 * FLASH_HZ);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_SEC = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [15:0]   digits_r, digits_nxt_s;
  logic [15:0]   target_r, target_nxt_s;
  logic          mode_r, mode_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [FW-1:0] flash_cnt_r;
  logic          flash_r;
  logic          done_r;
  logic          set_ev_s, run_ev_s, run_only_s;
  logic [15:0]   set_val_s, step_val_s, end_val_s;

  // Out-of-range switch digits read as zero so the display never holds non-BCD.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    if (d > max) begin
      return 4'd0;
    end else begin
      return d;
    end
  endfunction

  // One-second BCD decrement with borrow chain; 00:00 stays 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (v == 16'h0000) begin
      return 16'h0000;
    end
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // One-second BCD increment with carry chain; saturates at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (v == 16'h9959) begin
      return 16'h9959;
    end
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  bcd_timer_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set_db (
    .CLOCK_50 (CLOCK_50),
    .reset_btn(reset_btn),
    .btn_raw  (set_btn),
    .press    (set_ev_s)
  );

  bcd_timer_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_db (
    .CLOCK_50 (CLOCK_50),
    .reset_btn(reset_btn),
    .btn_raw  (run_btn),
    .press    (run_ev_s)
  );

  // Set has priority: a run press landing together with a set press is dropped.
  assign run_only_s = run_ev_s & ~set_ev_s;
  assign step_val_s = mode_r ? bcd_inc(digits_r) : bcd_dec(digits_r);
  assign end_val_s  = mode_r ? target_r : 16'h0000;

  // Next-state, digit, target, mode and prescaler logic.
  always_comb begin
    state_nxt_s  = state_r;
    digits_nxt_s = digits_r;
    target_nxt_s = target_r;
    mode_nxt_s   = mode_r;
    presc_nxt_s  = presc_r;
    set_val_s    = {clamp_digit(sw[7:4], 4'd9), clamp_digit(sw[3:0], 4'd9), digits_r[7:0]};
    case (state_r)
      ST_IDLE: begin
        if (set_ev_s) begin
          state_nxt_s = ST_SET_SEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SET_SEC: begin
        digits_nxt_s = {digits_r[15:8], clamp_digit(sw[7:4], 4'd5), clamp_digit(sw[3:0], 4'd9)};
        if (set_ev_s) begin
          state_nxt_s = ST_SET_MIN;
        end else begin
          state_nxt_s = ST_SET_SEC;
        end
      end
      ST_SET_MIN: begin
        digits_nxt_s = set_val_s;
        if (run_only_s) begin
          state_nxt_s = ST_RUN;
          mode_nxt_s  = count_up;
          presc_nxt_s = {PW{1'b0}};
          if (count_up) begin
            target_nxt_s = (set_val_s == 16'h0000) ? 16'h9959 : set_val_s;
            digits_nxt_s = 16'h0000;
          end else begin
            target_nxt_s = target_r;
          end
        end else begin
          state_nxt_s = ST_SET_MIN;
        end
      end
      ST_RUN: begin
        if (run_only_s) begin
          state_nxt_s = ST_PAUSE;
        end else if (digits_r == end_val_s) begin
          // Already at the end value on entry: finish without spending a tick.
          state_nxt_s = ST_DONE;
        end else if (presc_r == PRESC_LAST) begin
          presc_nxt_s  = {PW{1'b0}};
          digits_nxt_s = step_val_s;
          if (step_val_s == end_val_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          presc_nxt_s = presc_r + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (set_ev_s) begin
          state_nxt_s = ST_SET_SEC;
        end else if (run_ev_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (set_ev_s) begin
          state_nxt_s  = ST_IDLE;
          digits_nxt_s = 16'h0000;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        digits_nxt_s = 16'h0000;
      end
    endcase
  end

  // Main state, digit and prescaler registers.
  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      state_r  <= ST_IDLE;
      digits_r <= 16'h0000;
      target_r <= 16'h0000;
      mode_r   <= 1'b0;
      presc_r  <= {PW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      digits_r <= digits_nxt_s;
      target_r <= target_nxt_s;
      mode_r   <= mode_nxt_s;
      presc_r  <= presc_nxt_s;
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  // Flash phase runs only while staying in DONE and restarts from 0 on every entry.
  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      flash_cnt_r <= {FW{1'b0}};
      flash_r     <= 1'b0;
    end else if (state_r == ST_DONE && state_nxt_s == ST_DONE) begin
      if (flash_cnt_r == FLASH_LAST) begin
        flash_cnt_r <= {FW{1'b0}};
        flash_r     <= ~flash_r;
      end else begin
        flash_cnt_r <= flash_cnt_r + FW'(1);
      end
    end else begin
      flash_cnt_r <= {FW{1'b0}};
      flash_r     <= 1'b0;
    end
  end

  assign digits    = digits_r;
  assign state     = state_r;
  assign done      = done_r;
  assign led_flash = {10{flash_r}};
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (fast parameters: 10-cycle tick,
// 5-cycle flash half-period, 3-cycle debounce). Tick results go through a queue.
module tb_bcd_countdown_timer;
  logic        CLOCK_50 = 1'b0;
  logic        reset_btn = 1'b0;
  logic        set_btn = 1'b1;
  logic        run_btn = 1'b1;
  logic        count_up = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic [15:0] digits;
  logic [2:0]  state;
  logic        done;
  logic [9:0]  led_flash;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  bcd_countdown_timer #(
    .CLK_HZ(100), .TICK_HZ(10), .FLASH_HZ(10), .DEBOUNCE_CYC(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_btn(reset_btn),
    .set_btn  (set_btn),
    .run_btn  (run_btn),
    .count_up (count_up),
    .sw       (sw),
    .digits   (digits),
    .state    (state),
    .done     (done),
    .led_flash(led_flash)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent mm:ss model: seconds -> BCD digits.
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Drive a press (optionally after a settle gap) and wait, bounded, for the target state.
  task automatic press(input bit use_set, input bit use_run, input logic [2:0] tgt, input int pre);
    int n;
    repeat (pre) @(negedge CLOCK_50);
    if (use_set) set_btn = 1'b0;
    if (use_run) run_btn = 1'b0;
    n = 0;
    while (state !== tgt && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    set_btn = 1'b1;
    run_btn = 1'b1;
  endtask

  // Wait, bounded, until the digits change; report how many cycles it took.
  task automatic wait_change(input int budget, output int cyc);
    logic [15:0] prev;
    prev = digits;
    cyc = 0;
    while (digits === prev && cyc < budget) begin
      @(negedge CLOCK_50);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLOCK_50);
    reset_btn = 1'b1;
    @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0000 || state !== 3'd0 || done !== 1'b0 || led_flash !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_state: digits=%h state=%0d done=%b led=%h expected 0000/0/0/000",
               digits, state, done, led_flash);
    end
  endtask

  task automatic test_set_and_down_run;
    int cyc;
    logic [15:0] e;
    sw = 8'h7B;
    press(1'b1, 1'b0, 3'd1, 8);
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL enter_set_sec: state=%0d expected 1", state); end
    @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0000) begin n_fail++; $display("FAIL clamp_sec_7B: digits=%h expected 0000", digits); end
    sw = 8'h45;
    @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0045) begin n_fail++; $display("FAIL set_sec_45: digits=%h expected 0045", digits); end
    press(1'b1, 1'b0, 3'd2, 8);
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL enter_set_min: state=%0d expected 2", state); end
    sw = 8'hA5;
    @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0545) begin n_fail++; $display("FAIL clamp_min_A5: digits=%h expected 0545", digits); end
    sw = 8'h01;
    @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0145) begin n_fail++; $display("FAIL set_min_01: digits=%h expected 0145", digits); end
    count_up = 1'b0;
    press(1'b0, 1'b1, 3'd3, 8);
    n_checks++;
    if (state !== 3'd3 || digits !== 16'h0145) begin
      n_fail++;
      $display("FAIL enter_run_down: state=%0d digits=%h expected 3/0145", state, digits);
    end
    for (int s = 104; s >= 83; s--) exp_q.push_back(to_bcd(s));
    while (exp_q.size() > 0) begin
      wait_change(15, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (digits !== e || cyc != 10) begin
        n_fail++;
        $display("FAIL tick_down: digits=%h after %0d cycles expected %h after 10", digits, cyc, e);
      end
    end
    // Asynchronous reset mid-run at 01:23, between clock edges.
    #2 reset_btn = 1'b0;
    #1;
    n_checks++;
    if (digits !== 16'h0000 || state !== 3'd0 || led_flash !== 10'h000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: digits=%h state=%0d led=%h done=%b expected 0000/0/000/0",
               digits, state, led_flash, done);
    end
    repeat (2) @(negedge CLOCK_50);
    reset_btn = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    n_checks++;
    if (digits !== 16'h0000 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL after_reset_hold: digits=%h state=%0d expected 0000/0", digits, state);
    end
  endtask

  task automatic test_down_done;
    int cyc;
    logic [15:0] e;
    logic [9:0] prev_led;
    sw = 8'h02;
    press(1'b1, 1'b0, 3'd1, 8);
    press(1'b1, 1'b0, 3'd2, 8);
    sw = 8'h00;
    count_up = 1'b0;
    press(1'b0, 1'b1, 3'd3, 8);
    n_checks++;
    if (state !== 3'd3 || digits !== 16'h0002) begin
      n_fail++;
      $display("FAIL run_from_0002: state=%0d digits=%h expected 3/0002", state, digits);
    end
    exp_q.push_back(to_bcd(1));
    exp_q.push_back(to_bcd(0));
    while (exp_q.size() > 0) begin
      wait_change(15, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (digits !== e || cyc != 10) begin
        n_fail++;
        $display("FAIL tick_to_zero: digits=%h after %0d cycles expected %h after 10", digits, cyc, e);
      end
    end
    n_checks++;
    if (state !== 3'd5 || done !== 1'b1 || led_flash !== 10'h000) begin
      n_fail++;
      $display("FAIL done_same_update: state=%0d done=%b led=%h expected 5/1/000", state, done, led_flash);
    end
    for (int k = 0; k < 2; k++) begin
      prev_led = led_flash;
      cyc = 0;
      while (led_flash === prev_led && cyc < 20) begin
        @(negedge CLOCK_50);
        cyc++;
      end
      n_checks++;
      if (cyc != 5 || led_flash !== ~prev_led) begin
        n_fail++;
        $display("FAIL flash_toggle: led=%h after %0d cycles expected %h after 5", led_flash, cyc, ~prev_led);
      end
    end
    n_checks++;
    if (digits !== 16'h0000) begin n_fail++; $display("FAIL done_frozen: digits=%h expected 0000", digits); end
    press(1'b1, 1'b0, 3'd0, 8);
    n_checks++;
    if (state !== 3'd0 || digits !== 16'h0000 || done !== 1'b0 || led_flash !== 10'h000) begin
      n_fail++;
      $display("FAIL done_to_idle: state=%0d digits=%h done=%b led=%h expected 0/0000/0/000",
               state, digits, done, led_flash);
    end
  endtask

  task automatic test_up_pause;
    int cyc;
    logic [15:0] e;
    bit moved;
    count_up = 1'b1;
    sw = 8'h12;
    press(1'b1, 1'b0, 3'd1, 8);
    press(1'b1, 1'b0, 3'd2, 8);
    sw = 8'h00;
    press(1'b0, 1'b1, 3'd3, 8);
    count_up = 1'b0;
    n_checks++;
    if (state !== 3'd3 || digits !== 16'h0000) begin
      n_fail++;
      $display("FAIL up_entry: state=%0d digits=%h expected 3/0000", state, digits);
    end
    for (int s = 1; s <= 5; s++) exp_q.push_back(to_bcd(s));
    while (exp_q.size() > 0) begin
      wait_change(15, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (digits !== e || cyc != 10) begin
        n_fail++;
        $display("FAIL tick_up: digits=%h after %0d cycles expected %h after 10", digits, cyc, e);
      end
    end
    press(1'b0, 1'b1, 3'd4, 0);
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL pause: state=%0d expected 4", state); end
    moved = 1'b0;
    repeat (37) begin
      @(negedge CLOCK_50);
      if (digits !== 16'h0005) moved = 1'b1;
    end
    n_checks++;
    if (moved || digits !== 16'h0005 || state !== 3'd4) begin
      n_fail++;
      $display("FAIL pause_hold: digits=%h state=%0d moved=%b expected 0005/4/0", digits, state, moved);
    end
    press(1'b0, 1'b1, 3'd3, 0);
    n_checks++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL resume: state=%0d expected 3", state); end
    exp_q.push_back(to_bcd(6));
    wait_change(15, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (digits !== e || cyc != 5) begin
      n_fail++;
      $display("FAIL resume_prescaler: digits=%h after %0d cycles expected %h after 5", digits, cyc, e);
    end
    for (int s = 7; s <= 12; s++) exp_q.push_back(to_bcd(s));
    while (exp_q.size() > 0) begin
      wait_change(15, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (digits !== e || cyc != 10) begin
        n_fail++;
        $display("FAIL tick_up2: digits=%h after %0d cycles expected %h after 10", digits, cyc, e);
      end
    end
    n_checks++;
    if (state !== 3'd5 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL up_done: state=%0d done=%b expected 5/1", state, done);
    end
    press(1'b1, 1'b0, 3'd0, 8);
  endtask

  task automatic test_glitch_and_simultaneous;
    int n;
    count_up = 1'b0;
    sw = 8'h30;
    press(1'b1, 1'b0, 3'd1, 8);
    press(1'b1, 1'b0, 3'd2, 8);
    sw = 8'h00;
    press(1'b0, 1'b1, 3'd3, 8);
    press(1'b0, 1'b1, 3'd4, 8);
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL glitch_setup_pause: state=%0d expected 4", state); end
    repeat (8) @(negedge CLOCK_50);
    for (int g = 0; g < 5; g++) begin
      run_btn = 1'b0;
      @(negedge CLOCK_50);
      run_btn = 1'b1;
      repeat (3) @(negedge CLOCK_50);
    end
    repeat (8) @(negedge CLOCK_50);
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL glitch_ignored: state=%0d expected 4", state); end
    set_btn = 1'b0;
    run_btn = 1'b0;
    n = 0;
    while (state === 3'd4 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL set_run_priority: state=%0d expected 1", state); end
    // Keep holding: a held button must yield a single event.
    repeat (30) @(negedge CLOCK_50);
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL hold_single_event: state=%0d expected 1", state); end
    set_btn = 1'b1;
    run_btn = 1'b1;
    repeat (8) @(negedge CLOCK_50);
  endtask

  initial begin
    test_reset;
    test_set_and_down_run;
    test_down_done;
    test_up_pause;
    test_glitch_and_simultaneous;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
